// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer.
// Direction counter encoding and its saturating update rule live here so the
// entry storage and the write-path counter agree on one definition.
package btb_pkg;

    typedef enum logic [1:0] {
        STRONG_NOT_TAKEN = 2'b00,
        WEAK_NOT_TAKEN   = 2'b01,
        WEAK_TAKEN       = 2'b10,
        STRONG_TAKEN     = 2'b11
    } btb_state_t;

    // Instructions are word aligned; pc[1:0] never participates in lookup.
    localparam int unsigned BTB_WORD_ALIGN = 2;

    // One step of the 2-bit saturating direction predictor.
    function automatic btb_state_t sat_update(btb_state_t s, logic taken);
        btb_state_t r;
        r = s;
        unique case (s)
            STRONG_NOT_TAKEN: r = taken ? WEAK_NOT_TAKEN : STRONG_NOT_TAKEN;
            WEAK_NOT_TAKEN:   r = taken ? WEAK_TAKEN     : STRONG_NOT_TAKEN;
            WEAK_TAKEN:       r = taken ? STRONG_TAKEN   : WEAK_NOT_TAKEN;
            STRONG_TAKEN:     r = taken ? STRONG_TAKEN   : WEAK_TAKEN;
            default:          r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// 2-bit saturating direction counter step with enable; holds when disabled.
// Used once on the BTB write path to compute the updated entry counter.
module btb_sat_counter
    import btb_pkg::*;
(
    input  btb_state_t i_state,
    input  logic       i_en,
    input  logic       i_taken,
    output btb_state_t o_state
);

    // Next counter value: step toward the resolved direction when enabled.
    always_comb begin
        o_state = i_state;
        if (i_en) begin
            o_state = sat_update(i_state, i_taken);
        end
    end

endmodule

// File: rtl/btb_param.sv
// Parametrised direct-mapped branch target buffer.
// Combinational fetch lookup, registered resolve-time write port, synchronous
// flush of valid bits. Optional statistics counters: define BTB_STATS_EN.
module btb_param
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES    = 16,
    parameter logic [1:0]  INIT_STATE = 2'b10
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic [31:0] pc,
    output logic        hit,
    output logic        taken,
    output logic [31:0] target,
    input  logic        wen,
    input  logic [31:0] pc_w,
    input  logic [31:0] target_w,
    input  logic        taken_w
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] upd_cnt,
    output logic [31:0] upd_hit_cnt,
    output logic [31:0] mispred_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - BTB_WORD_ALIGN;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        btb_state_t       ctr;
        logic [31:0]      tgt;
    } entry_t;

    entry_t r_mem [ENTRIES];

    logic [IDX_W-1:0] w_ridx;
    logic [TAG_W-1:0] w_rtag;
    entry_t           w_rent;
    logic             w_rhit;

    logic [IDX_W-1:0] w_widx;
    logic [TAG_W-1:0] w_wtag;
    entry_t           w_went;
    logic             w_whit;
    btb_state_t       w_wctr_next;

    logic             w_unused_pc_lsbs;

    assign w_ridx = pc[IDX_W+BTB_WORD_ALIGN-1 -: IDX_W];
    assign w_rtag = pc[31 -: TAG_W];
    assign w_rent = r_mem[w_ridx];

    assign w_widx = pc_w[IDX_W+BTB_WORD_ALIGN-1 -: IDX_W];
    assign w_wtag = pc_w[31 -: TAG_W];
    assign w_went = r_mem[w_widx];
    assign w_whit = w_went.valid && (w_went.tag == w_wtag);

    assign w_unused_pc_lsbs = &{1'b0, pc[1:0], pc_w[1:0]};

    // Fetch lookup; RST gating keeps an undriven pc from reaching the outputs.
    always_comb begin
        w_rhit = !RST && w_rent.valid && (w_rent.tag == w_rtag);
        hit    = w_rhit;
        taken  = w_rhit && w_rent.ctr[1];
        target = w_rhit ? w_rent.tgt : '0;
    end

    btb_sat_counter u_wctr (
        .i_state (w_went.ctr),
        .i_en    (w_whit),
        .i_taken (taken_w),
        .o_state (w_wctr_next)
    );

    // Entry storage: reset, flush (drops any write), tag-hit update or allocate.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_mem[i] <= '{valid: 1'b0, tag: '0, ctr: WEAK_NOT_TAKEN, tgt: '0};
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else if (wen) begin
            if (w_whit) begin
                r_mem[w_widx].ctr <= w_wctr_next;
                if (taken_w) begin
                    r_mem[w_widx].tgt <= target_w;
                end
            end else if (taken_w) begin
                r_mem[w_widx] <= '{valid: 1'b1, tag: w_wtag,
                                   ctr: btb_state_t'(INIT_STATE), tgt: target_w};
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] r_upd_cnt;
    logic [31:0] r_upd_hit_cnt;
    logic [31:0] r_mispred_cnt;
    logic        w_accept;
    logic        w_mispred;

    assign w_accept  = wen && !flush;
    assign w_mispred = w_whit ? (w_went.ctr[1] != taken_w) : taken_w;

    // Saturating update statistics; only RST clears them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_upd_cnt     <= '0;
            r_upd_hit_cnt <= '0;
            r_mispred_cnt <= '0;
        end else if (w_accept) begin
            if (r_upd_cnt != '1) begin
                r_upd_cnt <= r_upd_cnt + 32'd1;
            end
            if (w_whit && (r_upd_hit_cnt != '1)) begin
                r_upd_hit_cnt <= r_upd_hit_cnt + 32'd1;
            end
            if (w_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign upd_cnt     = r_upd_cnt;
    assign upd_hit_cnt = r_upd_hit_cnt;
    assign mispred_cnt = r_mispred_cnt;
`endif

endmodule

// File: doc/btb_param.md
Name: btb_param

Overview:
- Parametrised branch target buffer; successor to the fixed 4-entry BTB.
- Direct-mapped, ENTRIES deep, with tag compare and a 2-bit saturating direction predictor per entry.
- Fetch stage does a combinational same-cycle lookup on its PC.
- Execute/memory stage writes resolved branch outcomes back through a registered write port.
- Adds tag-qualified hits, allocate-on-taken, and a synchronous flush, none of which the 4-entry version has.

Parameters:
- ENTRIES, 16, number of entries; power of two, 2..256.
- INIT_STATE, 2'b10, counter value on allocation (weak taken).

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous active-high reset.
- flush  input  1  invalidate all entries (synchronous).
- pc  input  32  fetch PC for lookup.
- hit  output  1  lookup matched a valid entry.
- taken  output  1  predict taken (hit & counter[1]).
- target  output  32  predicted target; 0 when hit=0.
- wen  input  1  resolved-branch update strobe.
- pc_w  input  32  PC of resolved branch.
- target_w  input  32  resolved target.
- taken_w  input  1  resolved direction.

Behaviour:
- Index and tag:
  - IDX_W = $clog2(ENTRIES).
  - index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
  - pc[1:0] is ignored. pc_w is split the same way.
- Entry fields: valid, tag, 2-bit counter, 32-bit target.
- Counter encoding: 11 strong taken, 10 weak taken, 01 weak not-taken, 00 strong not-taken.
- Reset (RST=1, asynchronous):
  - All valid=0, counters=01, targets=0, tags=0.
  - Outputs hit=0, taken=0, target=0.
- Read path is purely combinational, zero latency:
  - hit = valid[idx] & (tag[idx]==tag(pc)).
  - taken = hit & ctr[idx][1].
  - target = hit ? tgt[idx] : 0.
- Write on posedge CLK when wen=1:
  - Tag hit (valid & tag match):
    - counter += 1 saturating at 11 if taken_w, else -= 1 saturating at 00.
    - target overwritten with target_w only if taken_w=1.
  - Miss with taken_w=1: allocate; valid=1, tag=tag(pc_w), counter=INIT_STATE, target=target_w. Any aliased entry is replaced.
  - Miss with taken_w=0: no change; never allocate on not-taken.
- Same-cycle read and write to the same index: read returns pre-write contents. No bypass.
- Flush:
  - flush=1 at posedge clears every valid bit; counters, tags and targets are retained.
  - flush has priority over wen in the same cycle; the write is dropped.
- Reset asserted mid-operation overrides flush and wen immediately.
- X on pc while RST=1 must not propagate to outputs.

Optional Feature:
- BTB_STATS_EN defined: adds outputs upd_cnt, upd_hit_cnt and mispred_cnt, each 32 bits, saturating at 32'hFFFFFFFF, cleared only by RST (not by flush).
  - upd_cnt increments on every accepted write (wen & !flush).
  - upd_hit_cnt increments when that write tag-hits.
  - mispred_cnt increments when an accepted write tag-hits and the pre-update counter[1] != taken_w, or misses with taken_w=1.
- BTB_STATS_EN undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- btb_pkg (shared package):
  - btb_state_t: 2-bit enum with explicit encodings STRONG_NOT_TAKEN=2'b00 .. STRONG_TAKEN=2'b11.
  - BTB_WORD_ALIGN=2 constant.
  - Function sat_update(btb_state_t, logic taken) returning btb_state_t.
- Entry struct stays local to the module because the tag width depends on ENTRIES.
- One natural sub-module: btb_sat_counter, the 2-bit saturating counter with enable, used per entry or once on the write path.

Test Plan:
- Reset, then pc=32'h100 -> hit=0, taken=0, target=0.
- ENTRIES=16. wen, pc_w=32'h40, target_w=32'h80, taken_w=1; next cycle pc=32'h40 -> hit=1, taken=1, target=32'h80.
- Hysteresis on 32'h40:
  - Two more taken writes -> counter 11.
  - One not-taken write -> taken=1 (counter 10).
  - Second not-taken write -> hit=1, taken=0, target still 32'h80.
- Aliasing: entry at 32'h40 valid; taken write pc_w=32'h80 (idx 0, tag 2) -> lookup 32'h40 hit=0; lookup 32'h80 hit=1.
- No-allocate: not-taken write pc_w=32'h44 to an empty slot -> lookup 32'h44 hit=0. Read during that write's cycle shows old data.
- Flush and wen asserted together -> all lookups hit=0 and the write is dropped. With BTB_STATS_EN, upd_cnt is unchanged.
